// File: rtl/watchdog_multi.sv
// watchdog_multi: multi-channel windowed watchdog behind a byte-wide write bus.
//
// Every channel has its own frame length (F), earliest-valid-kick count (W)
// and reset-pulse length (L). A channel faults on an early kick or on a
// frame timeout. It then pulses its reset output for L+1 cycles and restarts
// by itself. F, W, L and STOP are write-protected by an AA/55 unlock
// sequence, which opens a short write window.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   we      in   write strobe; abus/dbus sampled only when we=1
//   abus    in   [1:0] register select, [CHW+1:2] channel select
//   dbus    in   write data
//   rstout  out  per-channel reset request
//   wdfail  out  per-channel sticky fail flag (cleared by INIT)
//   flstat  out  per-channel cause, 2 bits each: 00 none, 01 early kick,
//                10 timeout, 11 bad config
//   unlk    out  high while the config-write window is open
module watchdog_multi #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CHW        = 2,
    parameter int unsigned DW         = 8,
    parameter int unsigned UNLOCK_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [CHW+1:0]       abus,
    input  logic [DW-1:0]        dbus,
    output logic [NCH-1:0]       rstout,
    output logic [NCH-1:0]       wdfail,
    output logic [2*NCH-1:0]     flstat,
    output logic                 unlk
);

    localparam int unsigned UW = $clog2(UNLOCK_CYC + 1);

    localparam logic [1:0] REG_FRAME = 2'b00;
    localparam logic [1:0] REG_OPEN  = 2'b01;
    localparam logic [1:0] REG_CTRL  = 2'b10;
    localparam logic [1:0] REG_RLIM  = 2'b11;

    localparam logic [1:0] FL_NONE    = 2'b00;
    localparam logic [1:0] FL_EARLY   = 2'b01;
    localparam logic [1:0] FL_TIMEOUT = 2'b10;
    localparam logic [1:0] FL_BADCFG  = 2'b11;

    localparam logic [DW-1:0] KEY_ARM  = DW'(8'hAA);
    localparam logic [DW-1:0] KEY_OPEN = DW'(8'h55);

    typedef enum logic [1:0] {
        SEQ_LOCKED = 2'd0,
        SEQ_ARMED  = 2'd1,
        SEQ_OPEN   = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_RST  = 2'd2
    } ch_state_t;

    // ------------------------------------------------------------------
    // Unlock sequencer
    // ------------------------------------------------------------------
    seq_state_t     seq_q, seq_d;
    logic [UW-1:0]  wcnt_q, wcnt_d;
    logic           key_wr;

    // Unlock keys only count when written to channel 0, register 0.
    assign key_wr = we && (abus == '0);

    // Next-state logic for the unlock sequencer and its window counter.
    always_comb begin
        seq_d  = seq_q;
        wcnt_d = wcnt_q;
        case (seq_q)
            SEQ_LOCKED: begin
                if (key_wr && (dbus == KEY_ARM)) begin
                    seq_d = SEQ_ARMED;
                end
            end
            SEQ_ARMED: begin
                if (we) begin
                    if (key_wr && (dbus == KEY_OPEN)) begin
                        seq_d  = SEQ_OPEN;
                        wcnt_d = UW'(UNLOCK_CYC);
                    end else if (!(key_wr && (dbus == KEY_ARM))) begin
                        seq_d = SEQ_LOCKED;
                    end
                end
            end
            SEQ_OPEN: begin
                // Window counts down regardless of bus activity.
                if (wcnt_q <= UW'(1)) begin
                    seq_d  = SEQ_LOCKED;
                    wcnt_d = '0;
                end else begin
                    wcnt_d = wcnt_q - UW'(1);
                end
            end
            default: begin
                seq_d  = SEQ_LOCKED;
                wcnt_d = '0;
            end
        endcase
    end

    // Sequencer state register; unlk is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q  <= SEQ_LOCKED;
            wcnt_q <= '0;
            unlk   <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            wcnt_q <= wcnt_d;
            unlk   <= (seq_d == SEQ_OPEN);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel watchdogs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] f_q, w_q, l_q;
        logic [DW-1:0] cnt_q, cnt_d;
        logic [DW-1:0] rcnt_q, rcnt_d;
        ch_state_t     st_q, st_d;
        logic          rso_q, rso_d;
        logic          fail_q, fail_d;
        logic [1:0]    fl_q, fl_d;
        logic          sel, init, kick, stop;
        logic          cfg_ok, frame_end;
        logic          fault;
        logic [1:0]    fault_code;

        assign sel  = we && (abus[CHW+1:2] == CHW'(i));
        assign init = sel && (abus[1:0] == REG_CTRL) && dbus[3];
        assign kick = sel && (abus[1:0] == REG_CTRL) && dbus[2];
        assign stop = sel && (abus[1:0] == REG_CTRL) && dbus[0] && unlk;

        assign cfg_ok = (f_q != '0) && (w_q < f_q);
        // cnt+1 >= F in DW+1 bits: stays correct if F shrinks below cnt or is 0.
        assign frame_end = ({1'b0, cnt_q} + (DW+1)'(1)) >= {1'b0, f_q};

        // Protected configuration registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                f_q <= '0;
                w_q <= '0;
                l_q <= '0;
            end else if (sel && unlk) begin
                case (abus[1:0])
                    REG_FRAME: f_q <= dbus;
                    REG_OPEN:  w_q <= dbus;
                    REG_RLIM:  l_q <= dbus;
                    default:   ;
                endcase
            end
        end

        // Channel next-state logic; INIT beats STOP beats KICK/fault.
        always_comb begin
            st_d       = st_q;
            cnt_d      = cnt_q;
            rcnt_d     = rcnt_q;
            rso_d      = rso_q;
            fail_d     = fail_q;
            fl_d       = fl_q;
            fault      = 1'b0;
            fault_code = FL_NONE;

            if (init) begin
                cnt_d  = '0;
                rcnt_d = '0;
                rso_d  = 1'b0;
                fail_d = 1'b0;
                if (cfg_ok) begin
                    st_d = CH_RUN;
                    fl_d = FL_NONE;
                end else begin
                    st_d = CH_IDLE;
                    fl_d = FL_BADCFG;
                end
            end else if (stop) begin
                st_d   = CH_IDLE;
                cnt_d  = '0;
                rcnt_d = '0;
                rso_d  = 1'b0;
            end else begin
                case (st_q)
                    CH_RUN: begin
                        // A kick takes precedence over the timeout check,
                        // so a kick at cnt==F-1 is still valid.
                        if (kick) begin
                            if (cnt_q < w_q) begin
                                fault      = 1'b1;
                                fault_code = FL_EARLY;
                            end else begin
                                cnt_d = '0;
                            end
                        end else if (frame_end) begin
                            fault      = 1'b1;
                            fault_code = FL_TIMEOUT;
                        end else begin
                            cnt_d = cnt_q + DW'(1);
                        end
                    end
                    CH_RST: begin
                        if (rcnt_q == '0) begin
                            rso_d = 1'b0;
                            st_d  = CH_RUN;
                            cnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q - DW'(1);
                        end
                    end
                    default: ;
                endcase

                if (fault) begin
                    st_d   = CH_RST;
                    rso_d  = 1'b1;
                    fail_d = 1'b1;
                    rcnt_d = l_q;
                    fl_d   = fault_code;
                end
            end
        end

        // Channel state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q   <= CH_IDLE;
                cnt_q  <= '0;
                rcnt_q <= '0;
                rso_q  <= 1'b0;
                fail_q <= 1'b0;
                fl_q   <= FL_NONE;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                rcnt_q <= rcnt_d;
                rso_q  <= rso_d;
                fail_q <= fail_d;
                fl_q   <= fl_d;
            end
        end

        assign rstout[i]           = rso_q;
        assign wdfail[i]           = fail_q;
        assign flstat[2*i+1 : 2*i] = fl_q;
    end

endmodule

// File: tb/tb_watchdog_multi.sv
// Directed testbench for watchdog_multi (NCH=4, CHW=2, DW=8, UNLOCK_CYC=4).
module tb_watchdog_multi;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  abus;
    logic [7:0]  dbus;
    logic [3:0]  rstout;
    logic [3:0]  wdfail;
    logic [7:0]  flstat;
    logic        unlk;

    int pass_cnt;
    int total_cnt;

    watchdog_multi #(
        .NCH(4), .CHW(2), .DW(8), .UNLOCK_CYC(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .abus   (abus),
        .dbus   (dbus),
        .rstout (rstout),
        .wdfail (wdfail),
        .flstat (flstat),
        .unlk   (unlk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus write, sampled by the next rising edge; returns on the following falling edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        we   = 1'b1;
        abus = a;
        dbus = d;
        @(negedge clk);
        we   = 1'b0;
        abus = 4'h0;
        dbus = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts falling edges until rstout[ch] is seen high; max+1 if it never rises.
    task automatic wait_rise(input int ch, input int max, output int k);
        k = max + 1;
        for (int j = 1; j <= max; j++) begin
            @(negedge clk);
            if (rstout[ch] === 1'b1) begin
                k = j;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        idle(2);
        total_cnt++;
        if ({rstout, wdfail, flstat, unlk} !== 17'h0) $display("FAIL reset_outputs: got %h expected 0", {rstout, wdfail, flstat, unlk});
        else pass_cnt++;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_unlock_config();
        int hi;
        hi = 0;
        wr(4'h0, 8'hAA);
        idle(2);
        wr(4'h0, 8'h55);
        total_cnt++;
        if (unlk !== 1'b1) $display("FAIL unlock_rise: got %b expected 1", unlk);
        else pass_cnt++;
        hi = 1;
        wr(4'h0, 8'h0A); if (unlk === 1'b1) hi++;
        wr(4'h1, 8'h03); if (unlk === 1'b1) hi++;
        wr(4'h3, 8'h04); if (unlk === 1'b1) hi++;
        idle(1);         if (unlk === 1'b1) hi++;
        total_cnt++;
        if (hi !== 4) $display("FAIL unlock_width: got %0d cycles expected 4", hi);
        else pass_cnt++;
        total_cnt++;
        if (unlk !== 1'b0) $display("FAIL unlock_close: got %b expected 0", unlk);
        else pass_cnt++;
    endtask

    task automatic test_locked_write();
        int k;
        wr(4'h0, 8'h20);
        wr(4'h2, 8'h08);
        wait_rise(0, 40, k);
        total_cnt++;
        if (k !== 10) $display("FAIL locked_timeout_cycles: got %0d expected 10", k);
        else pass_cnt++;
        total_cnt++;
        if (flstat[1:0] !== 2'b10) $display("FAIL locked_flstat: got %b expected 10", flstat[1:0]);
        else pass_cnt++;
        total_cnt++;
        if (wdfail[0] !== 1'b1) $display("FAIL locked_wdfail: got %b expected 1", wdfail[0]);
        else pass_cnt++;
    endtask

    task automatic test_early_kick();
        int hi;
        int k;
        wr(4'h2, 8'h08);
        total_cnt++;
        if ({rstout[0], wdfail[0], flstat[1:0]} !== 4'b0000) $display("FAIL init_abort_rst: got %b expected 0000", {rstout[0], wdfail[0], flstat[1:0]});
        else pass_cnt++;
        idle(1);
        wr(4'h2, 8'h04);
        total_cnt++;
        if ({rstout[0], wdfail[0], flstat[1:0]} !== 4'b1101) $display("FAIL early_fault: got %b expected 1101", {rstout[0], wdfail[0], flstat[1:0]});
        else pass_cnt++;
        hi = 1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (rstout[0] === 1'b1) hi++;
        end
        @(negedge clk);
        total_cnt++;
        if (hi !== 5 || rstout[0] !== 1'b0) $display("FAIL early_pulse_width: got %0d cycles (now %b) expected 5 (now 0)", hi, rstout[0]);
        else pass_cnt++;
        wait_rise(0, 40, k);
        total_cnt++;
        if (k !== 10) $display("FAIL auto_restart_timeout: got %0d expected 10", k);
        else pass_cnt++;
    endtask

    task automatic test_valid_kicks();
        int bad;
        int k;
        bad = 0;
        wr(4'h2, 8'h08);
        for (int j = 0; j < 10; j++) begin
            idle(4);
            wr(4'h2, 8'h04);
            if (rstout[0] !== 1'b0 || wdfail[0] !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0 || flstat[1:0] !== 2'b00) $display("FAIL periodic_kicks: got %0d bad kicks, flstat %b expected 0, 00", bad, flstat[1:0]);
        else pass_cnt++;
        wait_rise(0, 40, k);
        total_cnt++;
        if (k !== 10) $display("FAIL timeout_after_last_kick: got %0d expected 10", k);
        else pass_cnt++;
        total_cnt++;
        if (flstat[1:0] !== 2'b10) $display("FAIL timeout_flstat: got %b expected 10", flstat[1:0]);
        else pass_cnt++;
    endtask

    task automatic test_kick_boundaries();
        wr(4'h2, 8'h08);
        idle(3);
        wr(4'h2, 8'h04);
        total_cnt++;
        if ({rstout[0], wdfail[0]} !== 2'b00) $display("FAIL kick_at_w: got %b expected 00", {rstout[0], wdfail[0]});
        else pass_cnt++;
        idle(9);
        wr(4'h2, 8'h04);
        total_cnt++;
        if ({rstout[0], wdfail[0]} !== 2'b00) $display("FAIL kick_at_f_minus_1: got %b expected 00", {rstout[0], wdfail[0]});
        else pass_cnt++;
        idle(2);
        wr(4'h2, 8'h04);
        total_cnt++;
        if (flstat[1:0] !== 2'b01) $display("FAIL kick_below_w: got %b expected 01", flstat[1:0]);
        else pass_cnt++;
    endtask

    task automatic test_bad_config();
        int k;
        wr(4'h2, 8'h08);
        wr(4'h0, 8'hAA);
        wr(4'h0, 8'h55);
        wr(4'h4, 8'h04);
        wr(4'h5, 8'h04);
        wr(4'h6, 8'h08);
        total_cnt++;
        if ({flstat[3:2], rstout[1], wdfail[1]} !== 4'b1100) $display("FAIL badcfg_ch1: got %b expected 1100", {flstat[3:2], rstout[1], wdfail[1]});
        else pass_cnt++;
        total_cnt++;
        if ({flstat[1:0], rstout[0], wdfail[0]} !== 4'b0000) $display("FAIL badcfg_ch0_isolated: got %b expected 0000", {flstat[1:0], rstout[0], wdfail[0]});
        else pass_cnt++;
        wr(4'h6, 8'h04);
        wait_rise(0, 40, k);
        total_cnt++;
        if (k !== 4 || rstout[1] !== 1'b0) $display("FAIL badcfg_ch0_timeout: got %0d (ch1 rst %b) expected 4 (ch1 rst 0)", k, rstout[1]);
        else pass_cnt++;
    endtask

    task automatic test_stop();
        int hi;
        wr(4'h0, 8'hAA);
        wr(4'h0, 8'h55);
        wr(4'h2, 8'h01);
        total_cnt++;
        if ({rstout[0], wdfail[0], flstat[1:0]} !== 4'b0110) $display("FAIL stop_in_rst: got %b expected 0110", {rstout[0], wdfail[0], flstat[1:0]});
        else pass_cnt++;
        hi = 0;
        wr(4'h2, 8'h04);
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (rstout[0] === 1'b1) hi++;
        end
        total_cnt++;
        if (hi !== 0 || flstat[1:0] !== 2'b10) $display("FAIL stop_stays_idle: got %0d reset cycles, flstat %b expected 0, 10", hi, flstat[1:0]);
        else pass_cnt++;
    endtask

    task automatic test_broken_unlock_reset();
        int k;
        wr(4'h0, 8'hAA);
        wr(4'h0, 8'h12);
        wr(4'h0, 8'h55);
        total_cnt++;
        if (unlk !== 1'b0) $display("FAIL broken_unlock: got %b expected 0", unlk);
        else pass_cnt++;
        wr(4'h2, 8'h08);
        wait_rise(0, 40, k);
        total_cnt++;
        if (k !== 10) $display("FAIL pre_reset_timeout: got %0d expected 10", k);
        else pass_cnt++;
        idle(2);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({rstout, wdfail, flstat, unlk} !== 17'h0) $display("FAIL async_reset: got %h expected 0", {rstout, wdfail, flstat, unlk});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        wr(4'h2, 8'h08);
        total_cnt++;
        if (flstat[1:0] !== 2'b11) $display("FAIL reset_clears_config: got %b expected 11", flstat[1:0]);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        we        = 1'b0;
        abus      = 4'h0;
        dbus      = 8'h00;
        test_reset();
        test_unlock_config();
        test_locked_write();
        test_early_kick();
        test_valid_kicks();
        test_kick_boundaries();
        test_bad_config();
        test_stop();
        test_broken_unlock_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
